// File: rtl/pe_pkg.sv
// Precision-mode encodings shared by the decomposable PE arithmetic blocks.
package pe_pkg;
    localparam int PRECISION_CONFIG_L = 2;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd0;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd2;
endpackage

// File: rtl/divider_decomposable_if.sv
// Operand/result handshake bundle for the decomposable divider.
interface divider_decomposable_if;
    import pe_pkg::*;

    logic                          in_vld;
    logic                          in_rdy;
    logic [31:0]                   in0;
    logic [31:0]                   in1;
    logic [PRECISION_CONFIG_L-1:0] mode;
    logic                          out_vld;
    logic                          out_rdy;
    logic [31:0]                   quotient;
    logic [31:0]                   remainder;
    logic [3:0]                    div_by_zero;

    modport master (
        output in_vld, in0, in1, mode, out_rdy,
        input  in_rdy, out_vld, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_vld, in0, in1, mode, out_rdy,
        output in_rdy, out_vld, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_decomposable.sv
// Radix-2 restoring unsigned divider: one 32-bit, two 16-bit or four 8-bit
// divisions per operation on a shared, lane-partitioned shift/subtract datapath.
module divider_decomposable
    import pe_pkg::*;
#(
    parameter int EACH_PART_LEN = 8,
    parameter int N_PARTS       = 4
) (
    input logic                  clk,
    input logic                  rst,
    divider_decomposable_if.slave dif
);

    localparam int W  = EACH_PART_LEN;
    localparam int TW = W * N_PARTS;
    localparam int CW = $clog2(TW);

    if (N_PARTS != 4) begin : g_parts_check
        $error("divider_decomposable supports only N_PARTS == 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          out_vld_q, out_vld_d;
    logic [TW-1:0]                 quotient_q, quotient_d;
    logic [TW-1:0]                 remainder_q, remainder_d;
    logic [N_PARTS-1:0]            dbz_q, dbz_d;

    logic [TW-1:0]                 rem_q, rem_d;
    logic [TW-1:0]                 dq_q, dq_d;
    logic [TW-1:0]                 dvs_q, dvs_d;
    logic [PRECISION_CONFIG_L-1:0] mode_q, mode_d;

    logic [TW-1:0]                 sh_a, diff_a, rem_nxt, dq_nxt;
    logic [N_PARTS-1:0]            ge_top;
    logic [N_PARTS-1:0]            dbz_calc;

    function automatic logic [CW-1:0] lane_last(input logic [PRECISION_CONFIG_L-1:0] m);
        case (m)
            PRECISION_CONFIG_8B:  return CW'(W - 1);
            PRECISION_CONFIG_16B: return CW'(2 * W - 1);
            default:              return CW'(TW - 1);
        endcase
    endfunction

    // Index of the most significant segment of the lane that owns segment k.
    function automatic int lane_top(input logic [PRECISION_CONFIG_L-1:0] m, input int k);
        case (m)
            PRECISION_CONFIG_8B:  return k;
            PRECISION_CONFIG_16B: return k | 1;
            default:              return N_PARTS - 1;
        endcase
    endfunction

    function automatic logic seg_start(input logic [PRECISION_CONFIG_L-1:0] m, input int k);
        case (m)
            PRECISION_CONFIG_8B:  return 1'b1;
            PRECISION_CONFIG_16B: return (k % 2) == 0;
            default:              return k == 0;
        endcase
    endfunction

    // One restoring iteration; borrows and shift bits are cut at lane boundaries.
    always_comb begin : p_iter
        logic         borrow;
        logic [W:0]   diff;
        logic [W-1:0] sh;
        logic         lane_ge;
        logic         dq_in;
        borrow  = 1'b0;
        diff    = '0;
        sh      = '0;
        lane_ge = 1'b0;
        dq_in   = 1'b0;
        sh_a    = '0;
        diff_a  = '0;
        ge_top  = '0;
        rem_nxt = '0;
        dq_nxt  = '0;
        for (int k = 0; k < N_PARTS; k++) begin
            if (seg_start(mode_q, k)) begin
                borrow = 1'b0;
                sh = {rem_q[k*W +: W-1], dq_q[lane_top(mode_q, k)*W + W-1]};
            end else begin
                sh = {rem_q[k*W +: W-1], rem_q[(k*W + TW - 1) % TW]};
            end
            diff   = {1'b0, sh} - {1'b0, dvs_q[k*W +: W]} - {{W{1'b0}}, borrow};
            borrow = diff[W];
            sh_a[k*W +: W]   = sh;
            diff_a[k*W +: W] = diff[W-1:0];
            // The bit shifted out of the lane MSB is the (W+1)-th remainder bit.
            ge_top[k] = rem_q[k*W + W-1] | ~borrow;
        end
        for (int k = 0; k < N_PARTS; k++) begin
            lane_ge = ge_top[lane_top(mode_q, k)];
            dq_in   = seg_start(mode_q, k) ? lane_ge : dq_q[(k*W + TW - 1) % TW];
            rem_nxt[k*W +: W] = lane_ge ? diff_a[k*W +: W] : sh_a[k*W +: W];
            dq_nxt[k*W +: W]  = {dq_q[k*W +: W-1], dq_in};
        end
    end

    always_comb begin : p_dbz
        dbz_calc = '0;
        case (mode_q)
            PRECISION_CONFIG_8B: begin
                for (int k = 0; k < N_PARTS; k++) begin
                    dbz_calc[k] = (dvs_q[k*W +: W] == '0);
                end
            end
            PRECISION_CONFIG_16B: begin
                dbz_calc[0] = (dvs_q[0 +: 2*W] == '0);
                dbz_calc[1] = (dvs_q[2*W +: 2*W] == '0);
            end
            default: dbz_calc[0] = (dvs_q == '0);
        endcase
    end

    always_comb begin : p_next
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_vld_d   = out_vld_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        mode_d      = mode_q;
        case (state_q)
            IDLE: begin
                if (dif.in_vld) begin
                    state_d = BUSY;
                    cnt_d   = lane_last(dif.mode);
                    rem_d   = '0;
                    dq_d    = dif.in0;
                    dvs_d   = dif.in1;
                    mode_d  = dif.mode;
                end
            end
            BUSY: begin
                rem_d = rem_nxt;
                dq_d  = dq_nxt;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_vld_d   = 1'b1;
                    quotient_d  = dq_nxt;
                    remainder_d = rem_nxt;
                    dbz_d       = dbz_calc;
                end
            end
            DONE: begin
                if (dif.out_rdy) begin
                    state_d   = IDLE;
                    out_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_vld_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_vld_q   <= out_vld_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Working registers carry no reset: they are always reloaded on accept.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        dq_q   <= dq_d;
        dvs_q  <= dvs_d;
        mode_q <= mode_d;
    end

    assign dif.in_rdy      = (state_q == IDLE) & ~rst;
    assign dif.out_vld     = out_vld_q;
    assign dif.quotient    = quotient_q;
    assign dif.remainder   = remainder_q;
    assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_decomposable.sv
// Directed-vector bench for divider_decomposable with hand-computed expectations.
module tb_divider_decomposable;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divider_decomposable_if dif();

    divider_decomposable #(.EACH_PART_LEN(8), .N_PARTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an operation at a negedge; returns after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [PRECISION_CONFIG_L-1:0] m);
        @(negedge clk);
        dif.in0    = a;
        dif.in1    = b;
        dif.mode   = m;
        dif.in_vld = 1'b1;
        @(posedge clk);
        #1;
        dif.in_vld = 1'b0;
        dif.in0    = ~a;
        dif.in1    = ~b;
        dif.mode   = ~m;
    endtask

    task automatic wait_vld(output int lat);
        lat = 0;
        while (!dif.out_vld && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [PRECISION_CONFIG_L-1:0] m, input int lat_exp,
                          input logic [31:0] eq, input logic [31:0] er, input logic [3:0] ed);
        int lat;
        dif.out_rdy = 1'b1;
        @(negedge clk);
        check({tag, "_in_rdy"}, 32'(dif.in_rdy), 32'd1);
        start_op(a, b, m);
        wait_vld(lat);
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_quotient"}, dif.quotient, eq);
        check({tag, "_remainder"}, dif.remainder, er);
        check({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(ed));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vld_drop"}, 32'(dif.out_vld), 32'd0);
        check({tag, "_rdy_back"}, 32'(dif.in_rdy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc[$];
        int results;
        int seen;
        dif.in_vld  = 1'b0;
        dif.in0     = '0;
        dif.in1     = '0;
        dif.mode    = PRECISION_CONFIG_32B;
        dif.out_rdy = 1'b1;
        rst         = 1'b1;

        #12;
        check("rst_out_vld", 32'(dif.out_vld), 32'd0);
        check("rst_quotient", dif.quotient, 32'd0);
        check("rst_remainder", dif.remainder, 32'd0);
        check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
        check("rst_in_rdy_low", 32'(dif.in_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_rdy_rel", 32'(dif.in_rdy), 32'd1);

        run_op("d32", 32'd100000, 32'd7, PRECISION_CONFIG_32B, 32, 32'd14285, 32'd5, 4'b0000);
        run_op("d16", 32'h03E8_FFFF, 32'h0003_0100, PRECISION_CONFIG_16B, 16,
               32'h014D_00FF, 32'h0001_00FF, 4'b0000);
        run_op("d8", 32'hFF64_0700, 32'h100A_0003, PRECISION_CONFIG_8B, 8,
               32'h0F0A_FF00, 32'h0F00_0700, 4'b0010);
        run_op("iso16", 32'h0001_0000, 32'h0001_0001, PRECISION_CONFIG_16B, 16,
               32'h0001_0000, 32'h0, 4'b0000);
        run_op("iso32", 32'h0001_0000, 32'h0001_0001, PRECISION_CONFIG_32B, 32,
               32'h0, 32'h0001_0000, 4'b0000);
        run_op("dz32", 32'h1234_5678, 32'h0, PRECISION_CONFIG_32B, 32,
               32'hFFFF_FFFF, 32'h1234_5678, 4'b0001);
        run_op("dz16", 32'hABCD_0064, 32'h0000_0007, PRECISION_CONFIG_16B, 16,
               32'hFFFF_000E, 32'hABCD_0002, 4'b0010);
        run_op("badmode", 32'd100000, 32'd7, 2'd3, 32, 32'd14285, 32'd5, 4'b0000);

        // Backpressure: result must hold while the producer side churns.
        dif.out_rdy = 1'b0;
        start_op(32'hFF64_0700, 32'h100A_0003, PRECISION_CONFIG_8B);
        wait_vld(lat);
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dif.in_vld = ~dif.in_vld;
            dif.in0    = $urandom;
            dif.in1    = $urandom;
            dif.mode   = PRECISION_CONFIG_L'(i);
            @(negedge clk);
            check("bp_out_vld", 32'(dif.out_vld), 32'd1);
            check("bp_in_rdy", 32'(dif.in_rdy), 32'd0);
            check("bp_quotient", dif.quotient, 32'h0F0A_FF00);
            check("bp_remainder", dif.remainder, 32'h0F00_0700);
            check("bp_dbz", 32'(dif.div_by_zero), 32'b0010);
        end
        dif.in_vld  = 1'b0;
        dif.out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_vld", 32'(dif.out_vld), 32'd0);
        check("bp_release_rdy", 32'(dif.in_rdy), 32'd1);

        // Back-to-back 8B operations with in_vld and out_rdy held high.
        dif.in0    = 32'h0101_010A;
        dif.in1    = 32'h0101_0103;
        dif.mode   = PRECISION_CONFIG_8B;
        dif.in_vld = 1'b1;
        results    = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (dif.in_rdy) acc.push_back(c);
            if (dif.out_vld) begin
                results++;
                check("b2b_quotient", dif.quotient, 32'h0101_0103);
            end
        end
        dif.in_vld = 1'b0;
        check("b2b_results", 32'(results >= 3), 32'd1);
        check("b2b_accepts", 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            check("b2b_ii_0", 32'(acc[1] - acc[0]), 32'd10);
            check("b2b_ii_1", 32'(acc[2] - acc[1]), 32'd10);
        end
        lat = 0;
        while (!dif.in_rdy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_drain", 32'(dif.in_rdy), 32'd1);

        // Kill a 32B operation mid-flight with an asynchronous reset.
        start_op(32'hDEAD_BEEF, 32'd3, PRECISION_CONFIG_32B);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("kill_out_vld", 32'(dif.out_vld), 32'd0);
        check("kill_quotient", dif.quotient, 32'd0);
        check("kill_remainder", dif.remainder, 32'd0);
        check("kill_dbz", 32'(dif.div_by_zero), 32'd0);
        check("kill_in_rdy", 32'(dif.in_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("kill_rdy_rel", 32'(dif.in_rdy), 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dif.out_vld) seen++;
        end
        check("kill_no_vld", 32'(seen), 32'd0);
        run_op("post_kill", 32'h0101_010A, 32'h0101_0103, PRECISION_CONFIG_8B, 8,
               32'h0101_0103, 32'h0000_0001, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
